// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_load_ctrl_pkg;

    localparam int unsigned IMEM_DEPTH_WORDS = 1024;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RECV  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_load_ctrl.sv
// Loads a program into instruction memory from a byte stream, holding the core meanwhile.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH_WORDS);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic [1:0]        cnt_q, cnt_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [31:0]       word_q, word_n;
    logic              len_err_q, len_err_n;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            word_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            cnt_q     <= cnt_n;
            len_q     <= len_n;
            word_q    <= word_n;
            len_err_q <= len_err_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        cnt_n     = cnt_q;
        len_n     = len_q;
        word_n    = word_q;
        len_err_n = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (load_len == '0) begin
                        state_n = ST_DONE;
                    end else if (load_len > MAX_LEN) begin
                        len_err_n = 1'b1;
                    end else begin
                        len_n   = load_len;
                        idx_n   = '0;
                        cnt_n   = '0;
                        state_n = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (load_abort) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (byte_valid) begin
                    word_n[{cnt_q, 3'b000} +: 8] = byte_data;
                    cnt_n = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_n = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Abort wins over the write happening this cycle
                if (load_abort) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx_q + ADDR_W'(1);
                    cnt_n   = '0;
                    state_n = ST_RECV;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state; forced low while reset is asserted
    assign byte_ready = !reset && (state_q == ST_RECV);
    assign imem_we    = !reset && (state_q == ST_WRITE) && !load_abort;
    assign imem_waddr = reset ? '0 : idx_q;
    assign imem_wdata = reset ? '0 : word_q;
    assign busy       = !reset && (state_q != ST_IDLE);
    assign core_hold  = !reset && (state_q != ST_IDLE);
    assign done       = !reset && (state_q == ST_DONE);
    assign len_err    = !reset && len_err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl.
module tb_imem_load_ctrl;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              len_err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int done_cnt      = 0;
    int len_err_cnt   = 0;
    int ready_in_we   = 0;

    imem_load_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .load_abort (load_abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    // Record memory writes and pulses mid-cycle
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(32'(imem_waddr));
            wd_q.push_back(imem_wdata);
            if (byte_ready) ready_in_we++;
        end
        if (done)    done_cnt++;
        if (len_err) len_err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt    = 0;
        len_err_cnt = 0;
        ready_in_we = 0;
    endtask

    task automatic start_load(input int len);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_ready && n < 100);
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rand_gap);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], rand_gap ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        load_abort = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {imem_waddr, imem_wdata[15:0], byte_ready, imem_we,
                              core_hold, busy, done, len_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // V1: two words, no gaps
        clear_log();
        start_load(2);
        @(negedge clk);
        check("v1_busy", 32'(busy), 32'd1);
        check("v1_hold", 32'(core_hold), 32'd1);
        @(posedge clk); #1;
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        @(negedge clk);
        check("v1_we_last", 32'(imem_we), 32'd1);
        @(negedge clk);
        check("v1_done_next", 32'(done), 32'd1);
        @(negedge clk);
        check("v1_hold_fall", 32'(core_hold), 32'd0);
        check("v1_busy_fall", 32'(busy), 32'd0);
        check("v1_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("v1_a0", wa_q[0], 32'd0);
            check("v1_d0", wd_q[0], 32'h0000_0013);
            check("v1_a1", wa_q[1], 32'd1);
            check("v1_d1", wd_q[1], 32'h0010_0093);
        end
        check("v1_done_cnt", 32'(done_cnt), 32'd1);

        // V2: same load with random valid gaps
        clear_log();
        start_load(2);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done("v2_done");
        @(negedge clk);
        check("v2_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("v2_a0", wa_q[0], 32'd0);
            check("v2_d0", wd_q[0], 32'h0000_0013);
            check("v2_a1", wa_q[1], 32'd1);
            check("v2_d1", wd_q[1], 32'h0010_0093);
        end
        check("v2_ready_in_we", 32'(ready_in_we), 32'd0);

        // V3: zero length and over-length
        clear_log();
        start_load(0);
        @(negedge clk);
        check("v3_zero_done", 32'(done), 32'd1);
        check("v3_zero_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("v3_zero_idle", 32'(busy), 32'd0);
        check("v3_zero_nwr", 32'(wa_q.size()), 32'd0);
        @(posedge clk); #1;
        start_load(1025);
        @(negedge clk);
        check("v3_len_err", 32'(len_err), 32'd1);
        check("v3_err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("v3_err_pulse", 32'(len_err), 32'd0);
        check("v3_err_busy2", 32'(busy), 32'd0);
        check("v3_err_cnt", 32'(len_err_cnt), 32'd1);

        // V4: abort after six bytes
        @(posedge clk); #1;
        clear_log();
        start_load(4);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        load_abort = 1'b1;
        @(posedge clk); #1;
        load_abort = 1'b0;
        @(negedge clk);
        check("v4_busy", 32'(busy), 32'd0);
        check("v4_hold", 32'(core_hold), 32'd0);
        check("v4_ready", 32'(byte_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("v4_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("v4_a0", wa_q[0], 32'd0);
            check("v4_d0", wd_q[0], 32'h0000_0013);
        end
        check("v4_no_done", 32'(done_cnt), 32'd0);

        // V5: reset during the second word's WRITE cycle
        @(posedge clk); #1;
        clear_log();
        start_load(4);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'h5566_7788, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("v5_rst_we", 32'(imem_we), 32'd0);
        check("v5_rst_outs", {imem_waddr, imem_wdata[15:0], byte_ready, imem_we,
                              core_hold, busy, done, len_err}, 32'd0);
        check("v5_rst_wdata", imem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("v5_idle", 32'(busy), 32'd0);
        check("v5_nwr", 32'(wa_q.size()), 32'd1);
        check("v5_no_done", 32'(done_cnt), 32'd0);
        @(posedge clk); #1;
        clear_log();
        start_load(1);
        send_word(32'hDDCC_BBAA, 1'b0);
        wait_done("v5_relaod_done");
        check("v5_nwr2", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("v5_a0", wa_q[0], 32'd0);
            check("v5_d0", wd_q[0], 32'hDDCC_BBAA);
        end

        // V6: full depth
        @(posedge clk); #1;
        clear_log();
        start_load(1024);
        for (int i = 0; i < 1024; i++)
            send_word(32'hA500_0000 | 32'(i), 1'b0);
        wait_done("v6_done");
        check("v6_nwr", 32'(wa_q.size()), 32'd1024);
        if (wa_q.size() == 1024) begin
            int bad;
            int zero_hits;
            bad = 0;
            zero_hits = 0;
            for (int i = 0; i < 1024; i++) begin
                if (wa_q[i] != 32'(i) || wd_q[i] != (32'hA500_0000 | 32'(i))) bad++;
                if (wa_q[i] == 32'd0) zero_hits++;
            end
            check("v6_seq", 32'(bad), 32'd0);
            check("v6_zero_once", 32'(zero_hits), 32'd1);
            check("v6_last_a", wa_q[1023], 32'd1023);
            check("v6_last_d", wd_q[1023], 32'hA500_03FF);
        end
        @(negedge clk);
        check("v6_hold_fall", 32'(core_hold), 32'd0);
        check("v6_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The block SHALL take parameters: DEPTH_WORDS, default 1024, instruction memory depth in 32-bit words; ADDR_W, default 10, word-index width, equal to clog2(DEPTH_WORDS).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  one-cycle request to begin a program load.
- load_len  in  ADDR_W+1  number of words to load, sampled with load_start.
- load_abort  in  1  terminates a load in progress.
- byte_valid  in  1  byte stream valid.
- byte_data  in  8  byte stream data.
- byte_ready  out  1  byte stream ready.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  word index to write.
- imem_wdata  out  32  word to write.
- core_hold  out  1  holds the processor in reset while loading.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse at load completion.
- len_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-003 The state machine SHALL have four states: IDLE, RECV, WRITE and DONE, all transitions on the rising edge of clk.
REQ-004 In IDLE, load_start=1 with 1<=load_len<=DEPTH_WORDS SHALL latch load_len, clear the word index and the byte count, and enter RECV.
REQ-005 In IDLE, load_start=1 with load_len=0 SHALL enter DONE directly, with no memory write.
REQ-006 In IDLE, load_start=1 with load_len>DEPTH_WORDS SHALL pulse len_err for one cycle and remain in IDLE.
REQ-007 byte_ready SHALL be 1 only in RECV; a byte transfers on a cycle where byte_valid and byte_ready are both 1.
REQ-008 Bytes SHALL assemble little-endian: transfer k (k=0..3) fills bits [8k+7:8k] of the word register.
REQ-009 The 4th transfer SHALL move the block to WRITE.
REQ-010 WRITE SHALL last exactly one cycle, during which imem_we=1, imem_waddr=current index and imem_wdata=assembled word.
REQ-011 imem_we SHALL be 0 in every other state.
REQ-012 After WRITE, if index=latched_len-1 the block SHALL enter DONE; otherwise it SHALL increment the index, clear the byte count and return to RECV.
REQ-013 The word index SHALL never wrap past DEPTH_WORDS-1; REQ-004 and REQ-006 guarantee this.
REQ-014 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in RECV, WRITE and DONE.
REQ-016 core_hold SHALL be 1 in RECV, WRITE and DONE, and 0 from the first IDLE cycle.
REQ-017 load_start outside IDLE SHALL be ignored, with no len_err.
REQ-018 load_abort=1 in RECV or WRITE SHALL enter IDLE next cycle with no write (it takes priority over a WRITE-cycle write) and no done pulse.
- Words already written SHALL remain in memory.
- A partially assembled word SHALL be discarded.
REQ-019 load_abort in IDLE or DONE SHALL have no effect.
REQ-020 Memory latency SHALL be zero-wait: the memory write completes in the WRITE cycle with no acknowledge.

Reset
REQ-021 reset=1 at any clock edge SHALL force IDLE and clear the index, byte count, latched length and word register.
REQ-022 During reset, all outputs SHALL be 0.
REQ-023 Reset during a load SHALL abandon the load with no write and no done pulse.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, RECV, WRITE, DONE) and the default DEPTH_WORDS constant, so the instruction memory and this block share one depth.
REQ-025 The design SHALL be a single module with no sub-modules; the byte assembler is too small to split out.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- V1 Load, 2 words: load_len=2, bytes 13,00,00,00,93,00,10,00 -> writes 0x00000013@0 and 0x00100093@1; done pulses the cycle after the 2nd WRITE; core_hold falls on the next cycle.
- V2 Backpressure: byte_valid toggled randomly -> identical words and addresses to V1; byte_ready stays 0 in the WRITE cycles.
- V3 Length bounds: load_len=0 -> done in the next cycle with no imem_we. load_len=1025 -> len_err pulses, busy stays 0.
- V4 Abort: load_len=4, abort after 6 bytes -> exactly one write (@0), no done, IDLE next cycle, core_hold=0.
- V5 Reset mid-load: reset asserted during WRITE of word 2 -> no write for that word, all outputs 0, a subsequent load starts at index 0.
- V6 Full depth: load_len=1024 -> last write at index 1023, then done; no write to index 0 after the start.
